fft_bitrev_reorder: RTL and testbench

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

---
 rtl/fft_bitrev_reorder_if.sv | 23 ++
 rtl/fft_bitrev_reorder.sv | 123 ++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_if.sv
// Streaming bus between an FFT core (bit-reversed order) and its natural-order consumer.
interface fft_bitrev_reorder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] sink_r;
  logic signed [DATA_WIDTH-1:0] sink_i;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] source_r;
  logic signed [DATA_WIDTH-1:0] source_i;
  logic                         sop_out;
  logic                         eop_out;

  modport master (
    output valid_in, sink_r, sink_i,
    input  valid_out, source_r, source_i, sop_out, eop_out
  );

  modport slave (
    input  valid_in, sink_r, sink_i,
    output valid_out, source_r, source_i, sop_out, eop_out
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping/pong reorder buffer: frames written at bit-reversed addresses, read back
// sequentially so bins leave in natural order with registered outputs.
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int POW        = 4
) (
  input logic                  clk,
  input logic                  rst,
  fft_bitrev_reorder_if.slave  bus
);
  localparam int N = 1 << POW;

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t                       r_state;
  logic [POW-1:0]               r_wr_cnt;
  logic [POW-1:0]               r_rd_addr;
  logic                         r_wr_bank;
  logic                         r_rd_bank;
  logic [1:0]                   r_full;
  logic                         r_valid;
  logic                         r_sop;
  logic                         r_eop;
  logic signed [DATA_WIDTH-1:0] r_source_r;
  logic signed [DATA_WIDTH-1:0] r_source_i;
  logic signed [DATA_WIDTH-1:0] r_mem_r [2][N];
  logic signed [DATA_WIDTH-1:0] r_mem_i [2][N];

  logic                         w_wr_last;
  logic                         w_rd_last;
  logic [1:0]                   w_full_nxt;
  logic signed [DATA_WIDTH-1:0] w_rd_r;
  logic signed [DATA_WIDTH-1:0] w_rd_i;

  function automatic logic [POW-1:0] bitrev(input logic [POW-1:0] a);
    logic [POW-1:0] ra;
    for (int b = 0; b < POW; b++) ra[b] = a[POW-1-b];
    return ra;
  endfunction

  assign w_wr_last = bus.valid_in && (r_wr_cnt == POW'(N-1));
  assign w_rd_last = (r_state == S_READ) && (r_rd_addr == POW'(N-1));
  assign w_rd_r    = r_mem_r[r_rd_bank][r_rd_addr];
  assign w_rd_i    = r_mem_i[r_rd_bank][r_rd_addr];

  // A write completing a frame and a read draining a frame always target different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
  end

  // Bank storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.valid_in) begin
      r_mem_r[r_wr_bank][bitrev(r_wr_cnt)] <= bus.sink_r;
      r_mem_i[r_wr_bank][bitrev(r_wr_cnt)] <= bus.sink_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_cnt   <= '0;
      r_rd_addr  <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_full     <= 2'b00;
      r_valid    <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_source_r <= '0;
      r_source_i <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (bus.valid_in) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      end

      // IDLE emits bin 0 on the same edge it enters READ, so bin 0 follows the
      // last write by one edge.
      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state    <= S_READ;
            r_valid    <= 1'b1;
            r_sop      <= 1'b1;
            r_eop      <= 1'b0;
            r_source_r <= w_rd_r;
            r_source_i <= w_rd_i;
            r_rd_addr  <= r_rd_addr + 1'b1;
          end else begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
          end
        end
        S_READ: begin
          r_valid    <= 1'b1;
          r_sop      <= (r_rd_addr == '0);
          r_eop      <= (r_rd_addr == POW'(N-1));
          r_source_r <= w_rd_r;
          r_source_i <= w_rd_i;
          if (r_rd_addr == POW'(N-1)) begin
            r_rd_addr <= '0;
            r_rd_bank <= ~r_rd_bank;
            r_state   <= r_full[~r_rd_bank] ? S_READ : S_IDLE;
          end else begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.valid_out = r_valid;
  assign bus.sop_out   = r_sop;
  assign bus.eop_out   = r_eop;
  assign bus.source_r  = r_source_r;
  assign bus.source_i  = r_source_i;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed table-driven bench for fft_bitrev_reorder (N=16, 16-bit samples).
module tb_fft_bitrev_reorder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  fft_bitrev_reorder_if #(.DATA_WIDTH(16)) bus ();

  fft_bitrev_reorder #(.DATA_WIDTH(16), .POW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int in_r;
    int in_i;
    int exp_r;
    int exp_i;
    int exp_sop;
    int exp_eop;
  } vec_t;

  typedef struct {
    int r;
    int i;
    int sop;
    int eop;
    int cyc;
  } obs_t;

  vec_t vec [16];
  obs_t q [$];

  always @(negedge clk) begin
    if (bus.valid_out) begin
      q.push_back('{r: int'(bus.source_r), i: int'(bus.source_i),
                    sop: int'(bus.sop_out), eop: int'(bus.eop_out), cyc: cyc});
    end else if (bus.sop_out || bus.eop_out) begin
      n_err++;
      $display("FAIL sop_eop_idle: sop=%0b eop=%0b with valid_out=0", bus.sop_out, bus.eop_out);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int r, input int i, output int t);
    bus.valid_in = 1'b1;
    bus.sink_r   = 16'(r);
    bus.sink_i   = 16'(i);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    t = cyc;
  endtask

  task automatic check_out(input string tag, input int nfr, input int t0, input bit special);
    int idx, er, ei;
    chk({tag, "_count"}, q.size(), 16 * nfr);
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < 16; k++) begin
        idx = 16 * f + k;
        er  = vec[k].exp_r + 16 * f;
        ei  = vec[k].exp_i + 16 * f;
        if (special && k == 8) begin
          er = -32768;
          ei = 32767;
        end
        if (idx < q.size()) begin
          chk($sformatf("%s_r[%0d]", tag, idx), q[idx].r, er);
          chk($sformatf("%s_i[%0d]", tag, idx), q[idx].i, ei);
          chk($sformatf("%s_sop[%0d]", tag, idx), q[idx].sop, vec[k].exp_sop);
          chk($sformatf("%s_eop[%0d]", tag, idx), q[idx].eop, vec[k].exp_eop);
          chk($sformatf("%s_cyc[%0d]", tag, idx), q[idx].cyc, t0 + 1 + 16 * f + k);
        end
      end
    end
  endtask

  initial begin
    int natural_r [16];
    int t, t0;
    natural_r = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int k = 0; k < 16; k++) begin
      vec[k].in_r    = k;
      vec[k].in_i    = 100 + k;
      vec[k].exp_r   = natural_r[k];
      vec[k].exp_i   = 100 + natural_r[k];
      vec[k].exp_sop = (k == 0) ? 1 : 0;
      vec[k].exp_eop = (k == 15) ? 1 : 0;
    end
    bus.valid_in = 1'b0;
    bus.sink_r   = '0;
    bus.sink_i   = '0;
    t  = 0;
    t0 = 0;

    // reset state
    idle(3);
    chk("rst_valid_out", int'(bus.valid_out), 0);
    chk("rst_sop_out", int'(bus.sop_out), 0);
    chk("rst_eop_out", int'(bus.eop_out), 0);
    chk("rst_source_r", int'(bus.source_r), 0);
    chk("rst_source_i", int'(bus.source_i), 0);
    rst = 1'b0;
    idle(2);

    // single frame
    q.delete();
    for (int k = 0; k < 16; k++) send(vec[k].in_r, vec[k].in_i, t);
    idle(20);
    check_out("single", 1, t, 1'b0);

    // three frames back to back
    q.delete();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) begin
        send(16 * f + vec[k].in_r, 16 * f + vec[k].in_i, t);
        if (f == 0 && k == 15) t0 = t;
      end
    end
    idle(20);
    check_out("b2b", 3, t0, 1'b0);

    // gapped input
    q.delete();
    for (int k = 0; k < 16; k++) begin
      send(vec[k].in_r, vec[k].in_i, t);
      t0 = t;
      idle(1);
    end
    idle(20);
    check_out("gapped", 1, t0, 1'b0);

    // reset mid-frame
    q.delete();
    for (int k = 0; k < 7; k++) send(50 + k, 200 + k, t);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) send(vec[k].in_r, vec[k].in_i, t);
    idle(20);
    check_out("rst_mid", 1, t, 1'b0);

    // reset during read at bin 5
    q.delete();
    for (int k = 0; k < 16; k++) send(vec[k].in_r, vec[k].in_i, t);
    idle(6);
    chk("rdrst_bin5_r", int'(bus.source_r), 10);
    rst = 1'b1;
    #1;
    chk("rdrst_valid_out", int'(bus.valid_out), 0);
    chk("rdrst_sop_out", int'(bus.sop_out), 0);
    chk("rdrst_eop_out", int'(bus.eop_out), 0);
    chk("rdrst_source_r", int'(bus.source_r), 0);
    chk("rdrst_source_i", int'(bus.source_i), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    idle(30);
    chk("rdrst_no_output", q.size(), 0);

    // signed extremes at input index 1 -> bin 8
    q.delete();
    for (int k = 0; k < 16; k++) begin
      if (k == 1) send(-32768, 32767, t);
      else        send(vec[k].in_r, vec[k].in_i, t);
    end
    idle(20);
    check_out("extreme", 1, t, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
